// File: rtl/ldpc_pin_frontend.sv
// ldpc_pin_frontend
//   Pin-side command front end for the LDPC encoder/decoder core. Asynchronous
//   pad inputs are synchronized, and a rising edge on the strobe executes one
//   command. WRITE fills the codeword buffer one bit at a time, START launches
//   the buffer to the core, READ returns one result bit on PO_output, and ABORT
//   returns the block to idle.
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   P_inputnoutput          pad mode (1 = host writes/starts, 0 = host reads)
//   P_input                 pad serial data bit for WRITE
//   P_in_out_sel[15:0]      [15] strobe, [14:13] opcode, [12:0] bit index
//   PO_output               registered read-back bit
//   cw_o/cw_valid_o/cw_ready_i     codeword handshake to the core
//   res_i/res_valid_i/res_ready_o  result handshake from the core
//   busy_o, done_o, err_o   status (err_o is sticky until ABORT or reset)
module ldpc_pin_frontend #(
    parameter int NN      = 208,
    parameter int IDX_W   = 13,
    parameter int WAIT_TO = 4096
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          P_inputnoutput,
    input  logic          P_input,
    input  logic [15:0]   P_in_out_sel,
    output logic          PO_output,
    output logic [NN-1:0] cw_o,
    output logic          cw_valid_o,
    input  logic          cw_ready_i,
    input  logic [NN-1:0] res_i,
    input  logic          res_valid_i,
    output logic          res_ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);
    localparam int                 SEL_W   = (NN > 1) ? $clog2(NN) : 1;
    localparam int                 CNT_W   = (WAIT_TO > 1) ? $clog2(WAIT_TO) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'((WAIT_TO > 0) ? WAIT_TO - 1 : 0);
    localparam logic [IDX_W:0]     NN_W    = (IDX_W + 1)'(NN);
    localparam bit                 TO_EN   = (WAIT_TO != 0);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    // Pad bundle: {mode, data, strobe/opcode/index}
    logic [17:0]      sync1_q, sync2_q;
    logic             stb3_q;
    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic             po_q, po_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NN-1:0]    cw_buf_q, cw_buf_d;
    logic [NN-1:0]    res_buf_q, res_buf_d;

    logic             mode, din, cmd_fire, idx_ok;
    logic [1:0]       op;
    logic [IDX_W-1:0] idx;
    logic [SEL_W-1:0] sel;

    assign mode     = sync2_q[17];
    assign din      = sync2_q[16];
    assign op       = sync2_q[14:13];
    assign idx      = sync2_q[IDX_W-1:0];
    assign sel      = idx[SEL_W-1:0];
    assign idx_ok   = ({1'b0, idx} < NN_W);
    // One command per synchronized rising edge, however long the strobe is held.
    assign cmd_fire = sync2_q[15] & ~stb3_q;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        po_d      = po_q;
        cnt_d     = cnt_q;
        cw_buf_d  = cw_buf_q;
        res_buf_d = res_buf_q;

        // Core-side handshakes and the WAIT timeout.
        case (state_q)
            S_LAUNCH: if (cw_ready_i) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still counts as success.
                if (res_valid_i) begin
                    res_buf_d = res_i;
                    state_d   = S_DONE;
                end else if (TO_EN && cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Pin commands; ABORT overrides any handshake taken in the same cycle.
        if (cmd_fire) begin
            if (op == OP_ABORT) begin
                state_d   = S_IDLE;
                err_d     = 1'b0;
                po_d      = 1'b0;
                res_buf_d = res_buf_q;
            end else if (mode != (op != OP_READ)) begin
                err_d = 1'b1;
            end else if (state_q == S_LAUNCH || state_q == S_WAIT) begin
                err_d = 1'b1;
            end else begin
                case (op)
                    OP_WRITE: if (idx_ok) cw_buf_d[sel] = din;
                              else        err_d = 1'b1;
                    OP_START: state_d = S_LAUNCH;
                    default: begin  // READ
                        if (state_q != S_DONE) begin
                            err_d = 1'b1;
                        end else if (idx_ok) begin
                            po_d = res_buf_q[sel];
                        end else begin
                            err_d = 1'b1;
                            po_d  = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stb3_q    <= 1'b0;
            state_q   <= S_IDLE;
            err_q     <= 1'b0;
            po_q      <= 1'b0;
            cnt_q     <= '0;
            cw_buf_q  <= '0;
            res_buf_q <= '0;
        end else begin
            sync1_q   <= {P_inputnoutput, P_input, P_in_out_sel};
            sync2_q   <= sync1_q;
            stb3_q    <= sync2_q[15];
            state_q   <= state_d;
            err_q     <= err_d;
            po_q      <= po_d;
            cnt_q     <= cnt_d;
            cw_buf_q  <= cw_buf_d;
            res_buf_q <= res_buf_d;
        end
    end

    assign PO_output   = po_q;
    assign cw_o        = cw_buf_q;
    assign cw_valid_o  = (state_q == S_LAUNCH);
    assign res_ready_o = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign busy_o      = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
endmodule

// File: tb/tb_ldpc_pin_frontend.sv
// Bench for ldpc_pin_frontend: directed scenarios with literal expectations,
// then randomized pin commands and core behaviour, all outputs compared every
// cycle against a pad-history based behavioural model.
module tb_ldpc_pin_frontend;
    localparam int NN  = 208;
    localparam int WTO = 16;
    localparam logic [1:0] WR = 2'd0, ST = 2'd1, RD = 2'd2, AB = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pmode = 1'b0, pdin = 1'b0;
    logic [15:0]   psel = '0;
    logic          po, cwv, resr, busy, done, err;
    logic [NN-1:0] cw;
    logic          cwr = 1'b0, resv = 1'b0;
    logic [NN-1:0] res = '0;

    always #5 clk = ~clk;

    ldpc_pin_frontend #(.NN(NN), .IDX_W(13), .WAIT_TO(WTO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .P_inputnoutput(pmode), .P_input(pdin),
        .P_in_out_sel(psel), .PO_output(po), .cw_o(cw), .cw_valid_o(cwv),
        .cw_ready_i(cwr), .res_i(res), .res_valid_i(resv), .res_ready_o(resr),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [NN-1:0] act, input logic [NN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A command runs at edge n when the pad strobe was high at edge n-2 and low
    // at edge n-3; its fields are the pad values seen at edge n-2.
    typedef enum {M_IDLE, M_LAUNCH, M_WAIT, M_DONE} ph_t;
    typedef struct packed { logic mode; logic din; logic [15:0] sel; } pad_t;
    pad_t          hist [3];      // [0]=edge n-1, [1]=n-2, [2]=n-3
    ph_t           m_ph, ph0;
    logic [NN-1:0] m_cw, m_res;
    logic          m_err, m_po, fire;
    pad_t          c;
    longint        edge_n = 0, wait_start = 0;
    int            midx;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_ph = M_IDLE; m_cw = '0; m_res = '0; m_err = 0; m_po = 0;
            for (int i = 0; i < 3; i++) hist[i] = '0;
        end else begin
            c    = hist[1];
            fire = c.sel[15] && !hist[2].sel[15];
            midx = int'(c.sel[12:0]);
            ph0  = m_ph;
            if (fire && c.sel[14:13] == AB) begin
                m_ph = M_IDLE; m_err = 0; m_po = 0;
            end else begin
                if (ph0 == M_LAUNCH && cwr) begin
                    m_ph = M_WAIT; wait_start = edge_n;
                end else if (ph0 == M_WAIT) begin
                    if (resv) begin m_res = res; m_ph = M_DONE; end
                    else if (edge_n - wait_start == WTO) begin m_err = 1; m_ph = M_IDLE; end
                end
                if (fire) begin
                    if (c.mode != (c.sel[14:13] != RD)) m_err = 1;
                    else if (ph0 == M_LAUNCH || ph0 == M_WAIT) m_err = 1;
                    else if (c.sel[14:13] == WR) begin
                        if (midx < NN) m_cw[midx] = c.din; else m_err = 1;
                    end else if (c.sel[14:13] == ST) m_ph = M_LAUNCH;
                    else begin
                        if (ph0 != M_DONE) m_err = 1;
                        else if (midx < NN) m_po = m_res[midx];
                        else begin m_err = 1; m_po = 0; end
                    end
                end
            end
            hist[2] = hist[1]; hist[1] = hist[0];
            hist[0] = {pmode, pdin, psel};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("PO_output", NN'(po), NN'(m_po));
            chk("cw_o", cw, m_cw);
            chk("cw_valid_o", NN'(cwv), NN'(m_ph == M_LAUNCH));
            chk("res_ready_o", NN'(resr), NN'(m_ph == M_IDLE || m_ph == M_WAIT));
            chk("busy_o", NN'(busy), NN'(m_ph == M_LAUNCH || m_ph == M_WAIT));
            chk("done_o", NN'(done), NN'(m_ph == M_DONE));
            chk("err_o", NN'(err), NN'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cmd(input logic [1:0] op, input int idx, input logic mode, input logic din,
                       input int hold = 3, input int gap = 3);
        @(negedge clk);
        pmode = mode; pdin = din; psel = {1'b1, op, 13'(idx)};
        repeat (hold) @(negedge clk);
        psel[15] = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    function automatic logic [NN-1:0] rnd_vec();
        logic [NN-1:0] v;
        for (int i = 0; i < NN; i++) v[i] = 1'($urandom % 2);
        return v;
    endfunction

    logic [NN-1:0] exp_cw;
    int            cnt;
    bit            stop_core;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst PO", NN'(po), '0);   chk("rst cw", cw, '0);
        chk("rst cwv", NN'(cwv), '0); chk("rst busy", NN'(busy), '0);
        chk("rst done", NN'(done), '0); chk("rst err", NN'(err), '0);
        chk("rst res_ready", NN'(resr), NN'(1));

        // Round trip
        exp_cw = '0; exp_cw[0] = 1'b1; exp_cw[5] = 1'b1; exp_cw[207] = 1'b1;
        cmd(WR, 0, 1, 1); cmd(WR, 5, 1, 1); cmd(WR, 207, 1, 1);
        @(negedge clk); pmode = 1; psel = {1'b1, ST, 13'd0};
        @(negedge clk); chk("start lat1", NN'(cwv), '0);
        @(negedge clk); chk("start lat2", NN'(cwv), '0);
        @(negedge clk); chk("start lat3", NN'(cwv), NN'(1));
        psel[15] = 1'b0;
        repeat (2) @(negedge clk);
        chk("cw literal", cw, exp_cw);
        cwr = 1'b1; @(negedge clk); cwr = 1'b0;
        res = ~exp_cw; resv = 1'b1; @(negedge clk); resv = 1'b0;
        chk("done after result", NN'(done), NN'(1));
        cmd(RD, 5, 0, 0);   chk("read 5", NN'(po), '0);
        cmd(RD, 6, 0, 0);   chk("read 6", NN'(po), NN'(1));
        cmd(RD, 207, 0, 0); chk("read 207", NN'(po), '0);
        chk("no err round trip", NN'(err), '0);

        // Error paths
        cmd(AB, 0, 0, 0);
        chk("abort po", NN'(po), '0);
        cmd(RD, 3, 0, 0);
        chk("read idle err", NN'(err), NN'(1)); chk("read idle busy", NN'(busy), '0);
        chk("read idle done", NN'(done), '0);
        cmd(AB, 0, 1, 0);   chk("abort clears err", NN'(err), '0);
        cmd(WR, 208, 1, 1); chk("wr oob err", NN'(err), NN'(1)); chk("wr oob cw", cw, exp_cw);
        cmd(AB, 0, 1, 0);
        cmd(WR, 1, 0, 1);   chk("wr mode err", NN'(err), NN'(1)); chk("wr mode cw", NN'(cw[1]), '0);
        cmd(AB, 0, 0, 0);   chk("abort clears err 2", NN'(err), '0);

        // Timeout: LAUNCH one cycle, then WAIT for WTO cycles
        cwr = 1'b1; cnt = 0;
        @(negedge clk); pmode = 1; psel = {1'b1, ST, 13'd0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) psel[15] = 1'b0;
            if (busy) cnt++;
        end
        cwr = 1'b0;
        chk("timeout busy cycles", NN'(cnt), NN'(WTO + 1));
        chk("timeout err", NN'(err), NN'(1)); chk("timeout idle", NN'(resr), NN'(1));
        res = rnd_vec(); resv = 1'b1; @(negedge clk); resv = 1'b0; @(negedge clk);
        chk("late result done", NN'(done), '0);
        cmd(AB, 0, 1, 0);

        // Backpressure, then ABORT coincident with cw_ready_i
        cmd(ST, 0, 1, 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cwv && cw === exp_cw) cnt++;
        end
        chk("backpressure cycles", NN'(cnt), NN'(50));
        @(negedge clk); pmode = 0; psel = {1'b1, AB, 13'd0};
        @(negedge clk); @(negedge clk); cwr = 1'b1;
        @(negedge clk); cwr = 1'b0; psel[15] = 1'b0;
        chk("abort wins cwv", NN'(cwv), '0); chk("abort wins busy", NN'(busy), '0);
        res = rnd_vec(); resv = 1'b1; @(negedge clk); resv = 1'b0; @(negedge clk);
        chk("abort drain done", NN'(done), '0);

        // Strobe edge behaviour
        cmd(ST, 0, 1, 0, 20, 3);
        chk("long strobe err", NN'(err), '0); chk("long strobe cwv", NN'(cwv), NN'(1));
        cmd(AB, 0, 1, 0);
        cmd(WR, 20, 1, 1, 3, 3); cmd(ST, 0, 1, 0, 3, 3);
        chk("two pulses bit", NN'(cw[20]), NN'(1)); chk("two pulses cwv", NN'(cwv), NN'(1));
        cmd(AB, 0, 1, 0);

        // Randomized commands against a randomized core
        stop_core = 1'b0;
        fork
            begin
                for (int n = 0; n < 250; n++) begin
                    logic [1:0] op;
                    int r, idx;
                    logic md;
                    r  = int'($urandom % 16);
                    op = (r < 7) ? WR : (r < 10) ? ST : (r < 14) ? RD : AB;
                    md = (op != RD);
                    if ($urandom % 10 == 0) md = ~md;
                    idx = ($urandom % 10 == 0) ? NN + int'($urandom % 50) : int'($urandom % NN);
                    cmd(op, idx, md, 1'($urandom % 2), 1 + int'($urandom % 4), 1 + int'($urandom % 4));
                end
                stop_core = 1'b1;
            end
            begin
                while (!stop_core) begin
                    @(negedge clk);
                    cwr  = 1'($urandom % 2);
                    resv = ($urandom % 12 == 0);
                    res  = rnd_vec();
                end
                cwr = 1'b0; resv = 1'b0;
            end
        join
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
